reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the out-of-order RISC-V core.
- Allocates ROB ids to instructions issued by the decoder and collects results from the ALU and LSB broadcast buses.
- Retires at most one entry per cycle, in program order, onto the register-file commit interface (is_commit / commit_rd / commit_data / commit_rob_id / commit_pc).
- Issues the global rollback on branch mispredict.

Parameters:
ROB_SZ, 16, entry count; power of two.
ROB_ID_W, 4, log2(ROB_SZ); width of every ROB id.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low: rst==0 resets all state immediately
rdy  in  1  global ready; when 0, all state holds and registered outputs hold
issue_valid  in  1  decoder issues one instruction this cycle
issue_type  in  2  0=REG (writes rd), 1=STORE, 2=BRANCH (conditional, no rd)
issue_rd  in  5  destination register
issue_pc  in  32  instruction pc
issue_pred_taken  in  1  fetch prediction for BRANCH
rob_full  out  1  combinational: count==ROB_SZ
issue_rob_id  out  ROB_ID_W  combinational: tail; id granted to the current issue, fed to regfile dependent_rob_id
alu_valid  in  1  ALU result broadcast
alu_rob_id  in  ROB_ID_W  tagged entry
alu_val  in  32  result value
alu_taken  in  1  actual branch outcome
alu_target  in  32  correct next pc if mispredicted
lsb_valid  in  1  LSB load/store-ready broadcast
lsb_rob_id  in  ROB_ID_W  tagged entry
lsb_val  in  32  load value (ignored for STORE)
qry1_rob_id, qry2_rob_id  in  ROB_ID_W  decoder operand lookups
qry1_ready, qry2_ready  out  1  combinational: entry ready, or matching same-cycle ALU/LSB broadcast
qry1_val, qry2_val  out  32  corresponding value (broadcast value takes priority)
is_commit  out  1  registered; one-cycle pulse per retired REG entry
commit_rd  out  5  registered
commit_data  out  32  registered
commit_rob_id  out  ROB_ID_W  registered
commit_pc  out  32  registered
commit_store  out  1  registered; one-cycle pulse telling the LSB to perform the head store
rollback  out  1  registered; one-cycle flush pulse to all units
rollback_pc  out  32  registered; redirect pc

Behaviour:
- Reset: head=tail=count=0; all entries busy=0, ready=0. All registered outputs are 0.
- Entry fields: busy, ready, type, rd, val, pc, pred_taken, taken, target.
- Issue: on a clk edge with rdy && issue_valid && !rob_full, entry[tail] is written with busy=1 and ready=0; tail increments modulo ROB_SZ.
- Issue while full is dropped; the decoder must hold the instruction.
- Write-back: alu_valid/lsb_valid set ready and val (and taken/target for ALU) on the addressed entry. Write-back to a non-busy entry is ignored. ALU and LSB writing the same id in the same cycle is illegal; if it happens, ALU wins.
- Commit condition: entry[head] is busy and ready. One retire per cycle. Default outputs each cycle: is_commit=0, commit_store=0, rollback=0.
  - REG: is_commit=1 with the entry's rd/val/id/pc. rd==0 is still pulsed; the regfile filters it.
  - STORE: commit_store=1, is_commit=0.
  - BRANCH correct: free the entry only.
  - BRANCH with taken!=pred_taken: rollback=1; rollback_pc = target if taken, else pc+4.
- Latency: an entry becoming ready at edge N retires at edge N+1; its outputs are visible during cycle N+1.
- Rollback edge: every entry is cleared and head=tail=count=0. Same-cycle issue and write-backs are discarded.
- Simultaneous issue and commit: count is unchanged. A full buffer that retires still refuses the same-cycle issue, because rob_full is based on count.
- Wrap-around: head and tail wrap naturally modulo ROB_SZ. Ids are reused only after the entry is freed.
- rdy==0: no issue, write-back or commit takes effect. Registered outputs hold their values (the regfile also gates on rdy).
- Reset asserted mid-operation clears everything asynchronously. This includes a pending rollback pulse.

Decomposition:
- Shared const package: ROB_SZ, ROB_ID_W, ROB type encodings (REG/STORE/BRANCH), DATA_WID, ADDR_WID, REG_ID_WID.
- No sub-module required. Optionally, rob_query_port: one combinational lookup with broadcast bypass, instantiated twice.

Test Plan:
- Issue REG rd=5 (id 0); ALU writes id 0 val=0x1234 at cycle 3 -> cycle 4: is_commit=1, commit_rd=5, commit_data=0x1234, commit_rob_id=0.
- Issue 16 entries -> rob_full=1, 17th issue dropped. Then commit id 0 with a simultaneous issue -> issue rejected that cycle, accepted next; issue_rob_id wraps to 0.
- Entries 0,1,2 issued; results arrive in order 2,0,1 -> commits occur strictly in order 0,1,2 on consecutive cycles.
- BRANCH pred_taken=0 at pc=0x100, ALU taken=1 target=0x200, younger REG entries pending -> rollback=1, rollback_pc=0x200 one cycle; next cycle count=0, no commits from the younger entries.
- qry1_rob_id=3 while ALU broadcasts id 3 val=7 the same cycle -> qry1_ready=1, qry1_val=7. Query of a not-ready id -> qry1_ready=0.
- Drop rst to 0 mid-stream with is_commit high -> all outputs 0 immediately, without waiting for a clk edge. rdy=0 for 3 cycles -> no state change.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants, entry layout and helpers for the circular reorder buffer.
// Imported by the top level and by the operand query port.
package reorder_buffer_pkg;

  localparam int ROB_SZ     = 16;
  localparam int ROB_ID_W   = 4;
  localparam int CNT_W      = ROB_ID_W + 1;
  localparam int DATA_WID   = 32;
  localparam int ADDR_WID   = 32;
  localparam int REG_ID_WID = 5;
  localparam int ROB_TYPE_W = 2;

  localparam logic [ROB_TYPE_W-1:0] ROB_TYPE_REG    = 2'd0;
  localparam logic [ROB_TYPE_W-1:0] ROB_TYPE_STORE  = 2'd1;
  localparam logic [ROB_TYPE_W-1:0] ROB_TYPE_BRANCH = 2'd2;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [ROB_TYPE_W-1:0] rtype;
    logic [REG_ID_WID-1:0] rd;
    logic [DATA_WID-1:0]   val;
    logic [ADDR_WID-1:0]   pc;
    logic                  pred_taken;
    logic                  taken;
    logic [ADDR_WID-1:0]   target;
  } rob_entry_t;

  // Correct next pc after a mispredicted conditional branch.
  function automatic logic [ADDR_WID-1:0] redirect_pc(input rob_entry_t e);
    return e.taken ? e.target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/reorder_buffer_query.sv
// One decoder operand lookup into the ROB, with same-cycle ALU/LSB broadcast bypass.
// Broadcast values take priority over the stored entry; ALU beats LSB.
module reorder_buffer_query
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_ID_W-1:0] qry_rob_id,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_WID-1:0] alu_val,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_WID-1:0] lsb_val,
  input  logic [ROB_SZ-1:0]   ent_ready,
  input  logic [DATA_WID-1:0] ent_val [ROB_SZ],
  output logic                qry_ready,
  output logic [DATA_WID-1:0] qry_val
);

  always_comb begin
    qry_ready = 1'b0;
    qry_val   = '0;
    if (alu_valid && (alu_rob_id == qry_rob_id)) begin
      qry_ready = 1'b1;
      qry_val   = alu_val;
    end else if (lsb_valid && (lsb_rob_id == qry_rob_id)) begin
      qry_ready = 1'b1;
      qry_val   = lsb_val;
    end else begin
      qry_ready = ent_ready[qry_rob_id];
      qry_val   = ent_val[qry_rob_id];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, collects ALU/LSB results,
// retires one entry per cycle in program order and raises rollback on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  issue_valid,
  input  logic [ROB_TYPE_W-1:0] issue_type,
  input  logic [REG_ID_WID-1:0] issue_rd,
  input  logic [ADDR_WID-1:0]   issue_pc,
  input  logic                  issue_pred_taken,
  output logic                  rob_full,
  output logic [ROB_ID_W-1:0]   issue_rob_id,
  input  logic                  alu_valid,
  input  logic [ROB_ID_W-1:0]   alu_rob_id,
  input  logic [DATA_WID-1:0]   alu_val,
  input  logic                  alu_taken,
  input  logic [ADDR_WID-1:0]   alu_target,
  input  logic                  lsb_valid,
  input  logic [ROB_ID_W-1:0]   lsb_rob_id,
  input  logic [DATA_WID-1:0]   lsb_val,
  input  logic [ROB_ID_W-1:0]   qry1_rob_id,
  input  logic [ROB_ID_W-1:0]   qry2_rob_id,
  output logic                  qry1_ready,
  output logic                  qry2_ready,
  output logic [DATA_WID-1:0]   qry1_val,
  output logic [DATA_WID-1:0]   qry2_val,
  output logic                  is_commit,
  output logic [REG_ID_WID-1:0] commit_rd,
  output logic [DATA_WID-1:0]   commit_data,
  output logic [ROB_ID_W-1:0]   commit_rob_id,
  output logic [ADDR_WID-1:0]   commit_pc,
  output logic                  commit_store,
  output logic                  rollback,
  output logic [ADDR_WID-1:0]   rollback_pc
);

  rob_entry_t            rob_q [ROB_SZ];
  rob_entry_t            rob_d [ROB_SZ];
  logic [ROB_ID_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  is_commit_q, is_commit_d;
  logic [REG_ID_WID-1:0] commit_rd_q, commit_rd_d;
  logic [DATA_WID-1:0]   commit_data_q, commit_data_d;
  logic [ROB_ID_W-1:0]   commit_rob_id_q, commit_rob_id_d;
  logic [ADDR_WID-1:0]   commit_pc_q, commit_pc_d;
  logic                  commit_store_q, commit_store_d;
  logic                  rollback_q, rollback_d;
  logic [ADDR_WID-1:0]   rollback_pc_q, rollback_pc_d;

  logic                  issue_ok_s, commit_fire_s, alu_hit_s, lsb_hit_s;
  rob_entry_t            head_ent_s;
  logic [ROB_SZ-1:0]     ent_ready_s;
  logic [DATA_WID-1:0]   ent_val_s [ROB_SZ];

  assign rob_full      = (count_q == CNT_W'(ROB_SZ));
  assign issue_rob_id  = tail_q;
  assign is_commit     = is_commit_q;
  assign commit_rd     = commit_rd_q;
  assign commit_data   = commit_data_q;
  assign commit_rob_id = commit_rob_id_q;
  assign commit_pc     = commit_pc_q;
  assign commit_store  = commit_store_q;
  assign rollback      = rollback_q;
  assign rollback_pc   = rollback_pc_q;

  always_comb begin
    for (int i = 0; i < ROB_SZ; i++) begin
      ent_ready_s[i] = rob_q[i].ready;
      ent_val_s[i]   = rob_q[i].val;
    end
  end

  reorder_buffer_query u_qry1 (
    .qry_rob_id (qry1_rob_id), .alu_valid (alu_valid), .alu_rob_id (alu_rob_id),
    .alu_val (alu_val), .lsb_valid (lsb_valid), .lsb_rob_id (lsb_rob_id),
    .lsb_val (lsb_val), .ent_ready (ent_ready_s), .ent_val (ent_val_s),
    .qry_ready (qry1_ready), .qry_val (qry1_val)
  );

  reorder_buffer_query u_qry2 (
    .qry_rob_id (qry2_rob_id), .alu_valid (alu_valid), .alu_rob_id (alu_rob_id),
    .alu_val (alu_val), .lsb_valid (lsb_valid), .lsb_rob_id (lsb_rob_id),
    .lsb_val (lsb_val), .ent_ready (ent_ready_s), .ent_val (ent_val_s),
    .qry_ready (qry2_ready), .qry_val (qry2_val)
  );

  assign head_ent_s    = rob_q[head_q];
  assign issue_ok_s    = rdy && issue_valid && !rob_full;
  assign commit_fire_s = rdy && head_ent_s.busy && head_ent_s.ready;
  assign alu_hit_s     = rdy && alu_valid && rob_q[alu_rob_id].busy;
  assign lsb_hit_s     = rdy && lsb_valid && rob_q[lsb_rob_id].busy;

  // Order matters: write-back, then issue, then retire; a mispredict wipes it all.
  always_comb begin
    rob_d           = rob_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    is_commit_d     = is_commit_q;
    commit_rd_d     = commit_rd_q;
    commit_data_d   = commit_data_q;
    commit_rob_id_d = commit_rob_id_q;
    commit_pc_d     = commit_pc_q;
    commit_store_d  = commit_store_q;
    rollback_d      = rollback_q;
    rollback_pc_d   = rollback_pc_q;
    if (rdy) begin
      is_commit_d    = 1'b0;
      commit_store_d = 1'b0;
      rollback_d     = 1'b0;
      if (lsb_hit_s) begin
        rob_d[lsb_rob_id].ready = 1'b1;
        rob_d[lsb_rob_id].val   = lsb_val;
      end else begin
        rob_d[lsb_rob_id] = rob_d[lsb_rob_id];
      end
      if (alu_hit_s) begin
        rob_d[alu_rob_id].ready  = 1'b1;
        rob_d[alu_rob_id].val    = alu_val;
        rob_d[alu_rob_id].taken  = alu_taken;
        rob_d[alu_rob_id].target = alu_target;
      end else begin
        rob_d[alu_rob_id] = rob_d[alu_rob_id];
      end
      if (issue_ok_s) begin
        rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rtype: issue_type, rd: issue_rd,
                          val: '0, pc: issue_pc, pred_taken: issue_pred_taken,
                          taken: 1'b0, target: '0};
        tail_d = tail_q + 4'd1;
      end else begin
        tail_d = tail_q;
      end
      if (commit_fire_s) begin
        rob_d[head_q] = '0;
        head_d        = head_q + 4'd1;
        case (head_ent_s.rtype)
          ROB_TYPE_REG: begin
            is_commit_d     = 1'b1;
            commit_rd_d     = head_ent_s.rd;
            commit_data_d   = head_ent_s.val;
            commit_rob_id_d = head_q;
            commit_pc_d     = head_ent_s.pc;
          end
          ROB_TYPE_STORE: commit_store_d = 1'b1;
          ROB_TYPE_BRANCH: begin
            if (head_ent_s.taken != head_ent_s.pred_taken) begin
              rollback_d    = 1'b1;
              rollback_pc_d = redirect_pc(head_ent_s);
            end else begin
              rollback_d    = 1'b0;
            end
          end
          default: rollback_d = 1'b0;
        endcase
      end else begin
        head_d = head_q;
      end
      case ({issue_ok_s, commit_fire_s})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      if (rollback_d) begin
        for (int i = 0; i < ROB_SZ; i++) rob_d[i] = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        count_d = count_d;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SZ; i++) rob_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      is_commit_q     <= 1'b0;
      commit_rd_q     <= '0;
      commit_data_q   <= '0;
      commit_rob_id_q <= '0;
      commit_pc_q     <= '0;
      commit_store_q  <= 1'b0;
      rollback_q      <= 1'b0;
      rollback_pc_q   <= '0;
    end else begin
      for (int i = 0; i < ROB_SZ; i++) rob_q[i] <= rob_d[i];
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      is_commit_q     <= is_commit_d;
      commit_rd_q     <= commit_rd_d;
      commit_data_q   <= commit_data_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_pc_q     <= commit_pc_d;
      commit_store_q  <= commit_store_d;
      rollback_q      <= rollback_d;
      rollback_pc_q   <= rollback_pc_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: issue, out-of-order write-back,
// in-order retire, full handling, rollback, query bypass, rdy stall and async reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        rob_full;
  logic [3:0]  issue_rob_id;
  logic        alu_valid, alu_taken;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_val, alu_target;
  logic        lsb_valid;
  logic [3:0]  lsb_rob_id;
  logic [31:0] lsb_val;
  logic [3:0]  qry1_rob_id, qry2_rob_id;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        is_commit, commit_store, rollback;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, commit_pc, rollback_pc;
  logic [3:0]  commit_rob_id;

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer dut (
    .clk (clk), .rst (rst), .rdy (rdy),
    .issue_valid (issue_valid), .issue_type (issue_type), .issue_rd (issue_rd),
    .issue_pc (issue_pc), .issue_pred_taken (issue_pred_taken),
    .rob_full (rob_full), .issue_rob_id (issue_rob_id),
    .alu_valid (alu_valid), .alu_rob_id (alu_rob_id), .alu_val (alu_val),
    .alu_taken (alu_taken), .alu_target (alu_target),
    .lsb_valid (lsb_valid), .lsb_rob_id (lsb_rob_id), .lsb_val (lsb_val),
    .qry1_rob_id (qry1_rob_id), .qry2_rob_id (qry2_rob_id),
    .qry1_ready (qry1_ready), .qry2_ready (qry2_ready),
    .qry1_val (qry1_val), .qry2_val (qry2_val),
    .is_commit (is_commit), .commit_rd (commit_rd), .commit_data (commit_data),
    .commit_rob_id (commit_rob_id), .commit_pc (commit_pc),
    .commit_store (commit_store), .rollback (rollback), .rollback_pc (rollback_pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0;
    issue_pred_taken = 1'b0;
    alu_valid = 1'b0; alu_rob_id = 4'd0; alu_val = 32'd0; alu_taken = 1'b0;
    alu_target = 32'd0;
    lsb_valid = 1'b0; lsb_rob_id = 4'd0; lsb_val = 32'd0;
    qry1_rob_id = 4'd0; qry2_rob_id = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pred);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_pred_taken = pred;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic alu_wb(input logic [3:0] id, input logic [31:0] v, input logic tk,
                        input logic [31:0] tgt);
    alu_valid = 1'b1; alu_rob_id = id; alu_val = v; alu_taken = tk; alu_target = tgt;
    tick();
    alu_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    idle_inputs();
    #2;
    check_val("rst_is_commit", 32'(is_commit), 32'd0);
    check_val("rst_rollback", 32'(rollback), 32'd0);
    check_val("rst_commit_store", 32'(commit_store), 32'd0);
    check_val("rst_rob_full", 32'(rob_full), 32'd0);
    check_val("rst_issue_id", 32'(issue_rob_id), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // basic REG issue, bypassed query, one-cycle retire latency
    issue(2'd0, 5'd5, 32'h40, 1'b0);
    check_val("t1_next_id", 32'(issue_rob_id), 32'd1);
    qry1_rob_id = 4'd0; #1;
    check_val("t1_qry_notready", 32'(qry1_ready), 32'd0);
    alu_valid = 1'b1; alu_rob_id = 4'd0; alu_val = 32'h1234; #1;
    check_val("t1_qry_byp_rdy", 32'(qry1_ready), 32'd1);
    check_val("t1_qry_byp_val", qry1_val, 32'h1234);
    tick();
    alu_valid = 1'b0;
    check_val("t1_no_commit_yet", 32'(is_commit), 32'd0);
    tick();
    check_val("t1_is_commit", 32'(is_commit), 32'd1);
    check_val("t1_commit_rd", 32'(commit_rd), 32'd5);
    check_val("t1_commit_data", commit_data, 32'h1234);
    check_val("t1_commit_id", 32'(commit_rob_id), 32'd0);
    check_val("t1_commit_pc", commit_pc, 32'h40);
    tick();
    check_val("t1_pulse_end", 32'(is_commit), 32'd0);

    // fill to 16, drop 17th, commit+issue same cycle
    do_reset();
    for (int i = 0; i < 16; i++) issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0);
    check_val("t2_full", 32'(rob_full), 32'd1);
    check_val("t2_tail_wrap", 32'(issue_rob_id), 32'd0);
    issue(2'd0, 5'd31, 32'h999, 1'b0);
    check_val("t2_drop_full", 32'(rob_full), 32'd1);
    check_val("t2_drop_id", 32'(issue_rob_id), 32'd0);
    alu_wb(4'd0, 32'hA0, 1'b0, 32'd0);
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd30; issue_pc = 32'h80;
    tick();
    check_val("t2_commit0", 32'(is_commit), 32'd1);
    check_val("t2_commit0_id", 32'(commit_rob_id), 32'd0);
    check_val("t2_commit0_rd", 32'(commit_rd), 32'd1);
    check_val("t2_commit0_data", commit_data, 32'hA0);
    check_val("t2_rejected_id", 32'(issue_rob_id), 32'd0);
    check_val("t2_not_full", 32'(rob_full), 32'd0);
    tick();
    issue_valid = 1'b0;
    check_val("t2_accepted_id", 32'(issue_rob_id), 32'd1);
    check_val("t2_full_again", 32'(rob_full), 32'd1);
    check_val("t2_no_commit", 32'(is_commit), 32'd0);

    // out-of-order results, in-order retire
    do_reset();
    issue(2'd0, 5'd10, 32'h0, 1'b0);
    issue(2'd0, 5'd11, 32'h4, 1'b0);
    issue(2'd0, 5'd12, 32'h8, 1'b0);
    alu_wb(4'd2, 32'h22, 1'b0, 32'd0);
    check_val("t3_wait_a", 32'(is_commit), 32'd0);
    lsb_valid = 1'b1; lsb_rob_id = 4'd0; lsb_val = 32'h20;
    tick();
    lsb_valid = 1'b0;
    check_val("t3_wait_b", 32'(is_commit), 32'd0);
    alu_wb(4'd1, 32'h21, 1'b0, 32'd0);
    check_val("t3_c0_id", 32'(commit_rob_id), 32'd0);
    check_val("t3_c0_data", commit_data, 32'h20);
    tick();
    check_val("t3_c1_id", 32'(commit_rob_id), 32'd1);
    check_val("t3_c1_data", commit_data, 32'h21);
    tick();
    check_val("t3_c2_id", 32'(commit_rob_id), 32'd2);
    check_val("t3_c2_rd", 32'(commit_rd), 32'd12);
    check_val("t3_c2_pulse", 32'(is_commit), 32'd1);
    tick();
    check_val("t3_done", 32'(is_commit), 32'd0);

    // mispredict taken, then not-taken, then a correct branch
    do_reset();
    issue(2'd2, 5'd0, 32'h100, 1'b0);
    issue(2'd0, 5'd3, 32'h104, 1'b0);
    issue(2'd0, 5'd4, 32'h108, 1'b0);
    alu_wb(4'd1, 32'd5, 1'b0, 32'd0);
    alu_wb(4'd0, 32'd0, 1'b1, 32'h200);
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rob_id = 4'd2; alu_val = 32'd9;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0;
    check_val("t4_rollback", 32'(rollback), 32'd1);
    check_val("t4_rollback_pc", rollback_pc, 32'h200);
    check_val("t4_no_commit", 32'(is_commit), 32'd0);
    check_val("t4_tail_reset", 32'(issue_rob_id), 32'd0);
    tick();
    check_val("t4_rollback_end", 32'(rollback), 32'd0);
    check_val("t4_flushed_a", 32'(is_commit), 32'd0);
    tick();
    check_val("t4_flushed_b", 32'(is_commit), 32'd0);
    issue(2'd2, 5'd0, 32'h300, 1'b1);
    alu_wb(4'd0, 32'd0, 1'b0, 32'h0);
    tick();
    check_val("t4_nt_rollback", 32'(rollback), 32'd1);
    check_val("t4_nt_pc", rollback_pc, 32'h304);
    issue(2'd2, 5'd0, 32'h400, 1'b1);
    issue(2'd0, 5'd7, 32'h404, 1'b0);
    alu_wb(4'd0, 32'd0, 1'b1, 32'h500);
    alu_wb(4'd1, 32'h77, 1'b0, 32'd0);
    check_val("t4_ok_no_rb", 32'(rollback), 32'd0);
    check_val("t4_ok_no_commit", 32'(is_commit), 32'd0);
    tick();
    check_val("t4_ok_commit", 32'(is_commit), 32'd1);
    check_val("t4_ok_id", 32'(commit_rob_id), 32'd1);

    // store retire and query bypass
    do_reset();
    issue(2'd1, 5'd0, 32'h600, 1'b0);
    alu_wb(4'd0, 32'd0, 1'b0, 32'd0);
    tick();
    check_val("t5_store", 32'(commit_store), 32'd1);
    check_val("t5_store_reg", 32'(is_commit), 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 32'(i * 16), 1'b0);
    qry1_rob_id = 4'd3; qry2_rob_id = 4'd2;
    #1;
    check_val("t5_q2_notready", 32'(qry2_ready), 32'd0);
    alu_valid = 1'b1; alu_rob_id = 4'd3; alu_val = 32'd7;
    lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_val = 32'd9;
    #1;
    check_val("t5_q1_byp_rdy", 32'(qry1_ready), 32'd1);
    check_val("t5_q1_byp_val", qry1_val, 32'd7);
    check_val("t5_q2_byp_val", qry2_val, 32'd9);
    tick();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    qry2_rob_id = 4'd1; #1;
    check_val("t5_q1_stored", qry1_val, 32'd7);
    check_val("t5_q2_pending", 32'(qry2_ready), 32'd0);

    // rdy stall holds outputs and state
    alu_wb(4'd0, 32'h77, 1'b0, 32'd0);
    tick();
    check_val("t6_commit0", 32'(commit_rob_id), 32'd0);
    rdy = 1'b0;
    alu_valid = 1'b1; alu_rob_id = 4'd1; alu_val = 32'h88;
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t6_hold_commit", 32'(is_commit), 32'd1);
      check_val("t6_hold_id", 32'(issue_rob_id), 32'd4);
    end
    rdy = 1'b1; alu_valid = 1'b0; issue_valid = 1'b0;
    tick();
    check_val("t6_no_wb_stall", 32'(is_commit), 32'd0);
    alu_wb(4'd1, 32'h99, 1'b0, 32'd0);
    tick();
    check_val("t6_commit1", 32'(commit_data), 32'h99);
    check_val("t6_commit1_hi", 32'(is_commit), 32'd1);

    // async reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    check_val("t7_async_commit", 32'(is_commit), 32'd0);
    check_val("t7_async_data", commit_data, 32'd0);
    check_val("t7_async_rd", 32'(commit_rd), 32'd0);
    check_val("t7_async_tail", 32'(issue_rob_id), 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
